// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module      : main_memory
// Description : 4096 x 16 unified program/data memory with a byte-serial boot
//               loader that fills the array from address 0 before the CPU runs.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0]     i_data,
    input  logic                  i_we,
    output logic [DWIDTH-1:0]     o_data,
    input  logic                  i_ld_valid,
    input  logic [7:0]            i_ld_byte,
    input  logic                  i_ld_last,
    output logic                  o_ld_ready,
    output logic [ADDR_WIDTH:0]   o_ld_count,
    output logic                  o_cpu_run,
    input  logic                  i_reload
);

    localparam int                  c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_LOAD_HI = 2'd1,
        ST_LOAD_LO = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [DWIDTH-1:0] mem [c_DEPTH];

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,    ptr_d;
    logic [7:0]            hi_q,     hi_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic [DWIDTH-1:0]     data_q,   data_d;
    logic                  run_q,    run_d;
    logic                  ready_q,  ready_d;

    logic                  w_accept;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DWIDTH-1:0]     w_mem_wdata;

    assign w_accept = i_ld_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hi_d        = hi_q;
        count_d     = count_q;
        data_d      = data_q;
        w_mem_we    = 1'b0;
        w_mem_addr  = ptr_q;
        w_mem_wdata = i_data;

        case (state_q)
            ST_INIT: begin
                state_d = ST_LOAD_HI;
            end
            ST_LOAD_HI: begin
                if (w_accept) begin
                    if (i_ld_last) begin
                        // Odd-length image: final word is zero-padded in its low byte.
                        w_mem_we    = 1'b1;
                        w_mem_wdata = DWIDTH'({i_ld_byte, 8'h00});
                        ptr_d       = ptr_q + ADDR_WIDTH'(1);
                        count_d     = count_q + (ADDR_WIDTH+1)'(1);
                        state_d     = ST_RUN;
                    end else begin
                        hi_d    = i_ld_byte;
                        state_d = ST_LOAD_LO;
                    end
                end
            end
            ST_LOAD_LO: begin
                if (w_accept) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = DWIDTH'({hi_q, i_ld_byte});
                    ptr_d       = ptr_q + ADDR_WIDTH'(1);
                    count_d     = count_q + (ADDR_WIDTH+1)'(1);
                    // Writing the top address fills the array; the pointer wraps to 0.
                    if (i_ld_last || (ptr_q == c_PTR_LAST)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD_HI;
                    end
                end
            end
            ST_RUN: begin
                w_mem_we    = i_we;
                w_mem_addr  = i_addr;
                w_mem_wdata = i_data;
                data_d      = i_we ? i_data : mem[i_addr];
                if (i_reload) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        run_d   = (state_d == ST_RUN);
        ready_d = (state_d == ST_LOAD_HI) || (state_d == ST_LOAD_LO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            hi_q    <= '0;
            count_q <= '0;
            data_q  <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            data_q  <= data_d;
            run_q   <= run_d;
            ready_q <= ready_d;
        end
    end

    // Array contents survive reset so a partial image remains visible.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign o_data     = data_q;
    assign o_ld_count = count_q;
    assign o_cpu_run  = run_q;
    assign o_ld_ready = ready_q;

endmodule
`default_nettype wire
